// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder: the carry-state encoding.
package serial_adder_pkg;

  // The state is the stored carry, so the encoding is the carry value itself.
  typedef enum logic {
    S0 = 1'b0,
    S1 = 1'b1
  } state_t;

endpackage : serial_adder_pkg

// File: rtl/full_adder.sv
// One-bit combinational full adder used as the Mealy output/next-state logic.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic half_sum;

  assign half_sum = a ^ b;
  assign s        = half_sum ^ cin;
  assign cout     = (a & b) | (cin & half_sum);

endmodule : full_adder

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: a two-state Mealy machine whose state is the carry.
module serial_adder
  import serial_adder_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  output logic F,
  output logic Cout
);

  state_t pState;
  logic   carry;

  assign carry = (pState == S1);

  // Sum and carry-out are combinational in the current bit; no pipeline delay.
  full_adder u_full_adder (
    .a    (A),
    .b    (B),
    .cin  (carry),
    .s    (F),
    .cout (Cout)
  );

  // NOTE: state registers use non-blocking assignments; the asynchronous clear
  // discards any partial sum without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pState <= S0;
    end else begin
      pState <= Cout ? S1 : S0;
    end
  end

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed vector table, exhaustive 4-bit sweep, reset corners.
module tb_serial_adder;

  logic clk;
  logic rst;
  logic A;
  logic B;
  logic F;
  logic Cout;

  int tests_run;
  int tests_failed;

  serial_adder dut (
    .clk  (clk),
    .rst  (rst),
    .A    (A),
    .B    (B),
    .F    (F),
    .Cout (Cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;
    logic [3:0] fseq;
  } vec_t;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Called at posedge+1; leaves the bench at posedge+3 with rst released.
  task automatic pulse_reset();
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  // Drives one bit pair, samples F/Cout at the falling edge, then lets the
  // rising edge consume the bit; returns at posedge+1 with the new state.
  task automatic do_bit(input logic a, input logic b, output logic f,
                        output logic c, output logic st);
    A = a;
    B = b;
    @(negedge clk);
    f = F;
    c = Cout;
    @(posedge clk);
    #1;
    st = dut.pState;
  endtask

  task automatic run_add(input logic [3:0] x, input logic [3:0] y,
                         output logic [4:0] r, output logic [3:0] fseq,
                         output logic [3:0] states);
    logic f, c, st;
    pulse_reset();
    r = '0;
    for (int k = 0; k < 4; k++) begin
      do_bit(x[k], y[k], f, c, st);
      fseq[k]   = f;
      states[k] = st;
      r[k]      = f;
      if (k == 3) r[4] = c;
    end
  endtask

  initial begin
    vec_t       vecs[8];
    logic [4:0] r;
    logic [3:0] fseq;
    logic [3:0] states;
    logic       f, c, st;
    int         sweep_bad;

    tests_run    = 0;
    tests_failed = 0;

    // Hand-computed sums and per-bit F sequences (bit 0 in fseq[0]).
    vecs[0] = '{x: 4'd15, y: 4'd15, sum: 5'd30, fseq: 4'b1110};
    vecs[1] = '{x: 4'd9,  y: 4'd7,  sum: 5'd16, fseq: 4'b0000};
    vecs[2] = '{x: 4'd0,  y: 4'd0,  sum: 5'd0,  fseq: 4'b0000};
    vecs[3] = '{x: 4'd0,  y: 4'd15, sum: 5'd15, fseq: 4'b1111};
    vecs[4] = '{x: 4'd3,  y: 4'd5,  sum: 5'd8,  fseq: 4'b1000};
    vecs[5] = '{x: 4'd10, y: 4'd6,  sum: 5'd16, fseq: 4'b0000};
    vecs[6] = '{x: 4'd5,  y: 4'd10, sum: 5'd15, fseq: 4'b1111};
    vecs[7] = '{x: 4'd1,  y: 4'd1,  sum: 5'd2,  fseq: 4'b0010};

    A   = 1'b0;
    B   = 1'b0;
    rst = 1'b0;
    #3;
    check("reset_state", 32'(dut.pState), 32'(1'b0));
    @(posedge clk);
    #1;
    check("reset_state_after_edge", 32'(dut.pState), 32'(1'b0));

    for (int i = 0; i < 8; i++) begin
      run_add(vecs[i].x, vecs[i].y, r, fseq, states);
      check($sformatf("vec%0d_sum_%0d+%0d", i, vecs[i].x, vecs[i].y),
            32'(r), 32'(vecs[i].sum));
      check($sformatf("vec%0d_fseq", i), 32'(fseq), 32'(vecs[i].fseq));
    end

    // 15+15 keeps the carry set after every edge; 0+0 never leaves S0.
    run_add(4'd15, 4'd15, r, fseq, states);
    check("15+15_states", 32'(states), 32'(4'b1111));
    run_add(4'd9, 4'd7, r, fseq, states);
    check("9+7_states", 32'(states), 32'(4'b1111));
    run_add(4'd0, 4'd0, r, fseq, states);
    check("0+0_states", 32'(states), 32'(4'b0000));
    run_add(4'd0, 4'd15, r, fseq, states);
    check("0+15_cout", 32'(r[4]), 32'(1'b0));

    // Mid-operation reset: carry clears asynchronously, then 1+1 restarts cleanly.
    pulse_reset();
    do_bit(1'b1, 1'b1, f, c, st);
    do_bit(1'b1, 1'b1, f, c, st);
    check("mid_reset_pre_state", 32'(st), 32'(1'b1));
    rst = 1'b0;
    #1;
    check("mid_reset_async_clear", 32'(dut.pState), 32'(1'b0));
    check("mid_reset_F", 32'(F), 32'(1'b0));
    check("mid_reset_Cout", 32'(Cout), 32'(1'b1));
    rst = 1'b1;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      do_bit(k == 0, k == 0, f, c, st);
      r[k] = f;
      if (k == 3) r[4] = c;
    end
    check("mid_reset_restart_1+1", 32'(r), 32'(5'd2));

    // Reset held with A=B=1: outputs reflect carry 0 and the state never moves.
    rst = 1'b0;
    A   = 1'b1;
    B   = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("held_F_%0d", k), 32'(F), 32'(1'b0));
      check($sformatf("held_Cout_%0d", k), 32'(Cout), 32'(1'b1));
      @(posedge clk);
      #1;
      check($sformatf("held_state_%0d", k), 32'(dut.pState), 32'(1'b0));
    end
    rst = 1'b1;

    // Exhaustive 4-bit sweep against the bench's own integer addition.
    sweep_bad = 0;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        run_add(4'(x), 4'(y), r, fseq, states);
        check($sformatf("sweep_%0d+%0d", x, y), 32'(r), 32'(x + y));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule : tb_serial_adder

// File: doc/serial_adder.md
# serial_adder

Bit-serial, LSB-first binary adder built as a two-state Mealy machine whose state is the stored carry. Each clock cycle it consumes one bit of each operand, produces one sum bit, and registers the carry for the next bit position. Reset clears the carry so a new operand pair can start. It sits behind any shift-register front end that presents operand bits one per cycle; operand width is set only by how many cycles the caller runs between resets.

## Interface
- No parameters; the operand length is unbounded and set by the caller.
- clk  in  1  Clock; the state updates on the rising edge.
- rst  in  1  Reset, asynchronous and active-low. While low, the carry state is forced to S0.
- A  in  1  Current operand-A bit, presented LSB first.
- B  in  1  Current operand-B bit, aligned with A.
- F  out  1  Sum bit for the current position (combinational Mealy output).
- Cout  out  1  Carry-out of the current position (combinational). After the final bit it is the MSB of the result.

## Operation
- States:
  - S0: carry = 0.
  - S1: carry = 1.
  - Encoding: 1 bit, S0 = 0, S1 = 1. The state register is named pState.
- Outputs, with c = (pState == S1):
  - F = A ^ B ^ c.
  - Cout = (A & B) | (c & (A ^ B)).
- Next state = S1 if Cout is 1, otherwise S0.
- Transitions:
  - S0 → S1 when A=B=1; otherwise stays in S0.
  - S1 → S0 when A=B=0; otherwise stays in S1.
- N-bit sum protocol:
  1. Reset.
  2. Drive bit k of A and B in cycle k, for k = 0..N-1.
  3. Capture F in each cycle as result bit k.
  4. In cycle N-1, capture Cout as result bit N.
- Result width: N+1 bits. There is no overflow condition; the final carry is the extra bit.
- Reset values:
  - pState = S0.
  - While reset is held, F = A ^ B and Cout = A & B (combinational outputs with carry 0).
- Reset mid-operation: the carry clears immediately, without waiting for a clock edge. The partial sum is discarded, and the next bit is treated as bit 0.
- No internal bit counter and no done flag; the caller sequences the operation.

## Timing
- Latency: F and Cout are valid combinationally in the same cycle the A/B bits are applied. There is no pipeline delay.
- The caller must sample F and Cout after the inputs settle and before the rising edge that consumes the bit.
- The carry advances once per rising edge. An N-bit add takes N cycles after reset is released.
- Deassertion of rst must meet recovery/removal timing relative to clk. The first edge after release consumes bit 0.
- A/B must be stable through setup/hold around each rising edge. No other handshake exists.

## Structure
- Shared package holds the state type and the constants S0/S1.
- One natural sub-module: full_adder, which is purely combinational (a, b, cin → s, cout).
- The top module contains only the asynchronous-reset state register and the next-state logic derived from full_adder.cout.
- No other hierarchy.

## Test plan
- Exhaustive 4-bit sweep:
  - Stimulus: every x, y in 0..15; reset before each pair; 4 bits LSB first.
  - Required response: {Cout at bit 3, F3..F0} == x+y for all 256 pairs.
- 15+15:
  - F sequence is 0,1,1,1 and Cout=1 at bit 3, giving result 30.
  - The state is S1 after every edge.
- 9+7:
  - F is 0 on every bit and Cout=1 at bit 3, giving 16.
  - This checks full carry ripple through S1.
- 0+0 and 0+15:
  - 0+0 gives result 0 with the state held in S0.
  - 0+15 gives result 15 and Cout=0.
- Reset mid-operation:
  - Run 3+3 for two bits; the state reaches S1.
  - Pull rst low between clock edges; pState must read S0 immediately.
  - Restart with 1+1; the result must be 2.
- Reset held:
  - With rst low, toggle clk with A=B=1.
  - F=0 and Cout=1 every cycle; the state stays S0.
